pong_referee: RTL and testbench



---
 rtl/pong_referee.sv | 191 +++++++++++++++++++
 tb/tb_pong_referee.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_referee.sv
// -----------------------------------------------------------------------------
// pong_referee
//
// Game referee that sits downstream of the ball block and closes the loop back
// to it. Compares the ball position against both paddles, reports per-side
// paddle hits, detects misses, keeps both scores and runs the game-state FSM
// (IDLE -> PLAY -> POINT -> PLAY ... -> OVER). After every point it holds the
// ball in reset (ballResetN low) so the ball re-serves from its load position.
//
// Optional feature macro: PONG_REFEREE_GRACE_EN
//   When defined, each paddle span is widened by one row on each side
//   (paddleY-1 .. paddleY+PADDLE_HEIGHT, clamped to 0..31). This applies to
//   the hit outputs and the miss test alike.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   xPosition[5:0] in   ball x coordinate
//   yPosition[4:0] in   ball y coordinate
//   isBallMoving   in   one-cycle strobe, ball steps this cycle
//   leftPaddleY    in   top row of the left paddle
//   rightPaddleY   in   top row of the right paddle
//   startButton    in   start/restart request (synchronous level)
//   isHittingLeft  out  registered: ball y within left paddle span
//   isHittingRight out  registered: ball y within right paddle span
//   scoreLeft      out  left player score
//   scoreRight     out  right player score
//   ballResetN     out  active-low ball re-serve request
//   gameState      out  0=IDLE, 1=PLAY, 2=POINT, 3=OVER
// -----------------------------------------------------------------------------
module pong_referee #(
    parameter int PADDLE_HEIGHT = 4,
    parameter int LEFT_COL      = 1,
    parameter int RIGHT_COL     = 62,
    parameter int WIN_SCORE     = 9,
    parameter int POINT_HOLD    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] xPosition,
    input  logic [4:0] yPosition,
    input  logic       isBallMoving,
    input  logic [4:0] leftPaddleY,
    input  logic [4:0] rightPaddleY,
    input  logic       startButton,
    output logic       isHittingLeft,
    output logic       isHittingRight,
    output logic [3:0] scoreLeft,
    output logic [3:0] scoreRight,
    output logic       ballResetN,
    output logic [1:0] gameState
);

    localparam int CNT_W = $clog2(POINT_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [3:0]       score_left_next, score_right_next;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
    logic             start_q;
    logic             start_armed;
    logic             start_pulse;
    logic             span_left, span_right;
    logic             miss_left, miss_right;
    logic             hit_enable;

    // Span test done 6 bits wide so paddleY+PADDLE_HEIGHT-1 never wraps
    // back into the low rows.
    function automatic logic in_span(input logic [4:0] y, input logic [4:0] top);
        logic [5:0] y6;
        logic [5:0] lo;
        logic [5:0] hi;
        y6 = {1'b0, y};
`ifdef PONG_REFEREE_GRACE_EN
        lo = (top == 5'd0) ? 6'd0 : ({1'b0, top} - 6'd1);
        hi = {1'b0, top} + 6'(PADDLE_HEIGHT);
        if (hi > 6'd31) hi = 6'd31;
`else
        lo = {1'b0, top};
        hi = {1'b0, top} + 6'(PADDLE_HEIGHT) - 6'd1;
`endif
        return (y6 >= lo) && (y6 <= hi);
    endfunction

    assign span_left  = in_span(yPosition, leftPaddleY);
    assign span_right = in_span(yPosition, rightPaddleY);

    // start_armed only rises once the button has been seen low after reset,
    // so a button held through reset cannot start a game on release.
    assign start_pulse = startButton & ~start_q & start_armed;

    // Left miss wins if both columns ever match (only possible with bad params).
    assign miss_left  = isBallMoving && (xPosition == 6'(LEFT_COL)) && !span_left;
    assign miss_right = isBallMoving && (xPosition >= 6'(RIGHT_COL)) && !span_right
                        && !miss_left;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and score/counter update logic
    always_comb begin
        state_next       = state;
        score_left_next  = scoreLeft;
        score_right_next = scoreRight;
        hold_cnt_next    = hold_cnt;
        case (state)
            IDLE: begin
                if (start_pulse) state_next = PLAY;
            end
            PLAY: begin
                if (miss_left) begin
                    score_right_next = scoreRight + 4'd1;
                    if (score_right_next == 4'(WIN_SCORE)) begin
                        state_next = OVER;
                    end else begin
                        state_next    = POINT;
                        hold_cnt_next = CNT_W'(POINT_HOLD - 1);
                    end
                end else if (miss_right) begin
                    score_left_next = scoreLeft + 4'd1;
                    if (score_left_next == 4'(WIN_SCORE)) begin
                        state_next = OVER;
                    end else begin
                        state_next    = POINT;
                        hold_cnt_next = CNT_W'(POINT_HOLD - 1);
                    end
                end
            end
            POINT: begin
                if (hold_cnt == '0) begin
                    state_next = PLAY;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            OVER: begin
                if (start_pulse) begin
                    score_left_next  = 4'd0;
                    score_right_next = 4'd0;
                    state_next       = PLAY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the ball is released only while play is live
    always_comb begin
        ballResetN = 1'b0;
        hit_enable = 1'b0;
        gameState  = state;
        if (state == PLAY) begin
            ballResetN = 1'b1;
            hit_enable = 1'b1;
        end
    end

    // Scores, hold counter, start edge detection and registered hit outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scoreLeft      <= 4'd0;
            scoreRight     <= 4'd0;
            hold_cnt       <= '0;
            start_q        <= 1'b0;
            start_armed    <= 1'b0;
            isHittingLeft  <= 1'b0;
            isHittingRight <= 1'b0;
        end else begin
            scoreLeft      <= score_left_next;
            scoreRight     <= score_right_next;
            hold_cnt       <= hold_cnt_next;
            start_q        <= startButton;
            if (!startButton) start_armed <= 1'b1;
            isHittingLeft  <= hit_enable & span_left;
            isHittingRight <= hit_enable & span_right;
        end
    end

endmodule

// File: tb/tb_pong_referee.sv
module tb_pong_referee;

    logic       clk;
    logic       reset;
    logic [5:0] xPosition;
    logic [4:0] yPosition;
    logic       isBallMoving;
    logic [4:0] leftPaddleY;
    logic [4:0] rightPaddleY;
    logic       startButton;
    logic       isHittingLeft;
    logic       isHittingRight;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic       ballResetN;
    logic [1:0] gameState;

    int checks = 0;
    int errors = 0;
    int n_point;
    logic low_ok;

    pong_referee dut (
        .clk            (clk),
        .reset          (reset),
        .xPosition      (xPosition),
        .yPosition      (yPosition),
        .isBallMoving   (isBallMoving),
        .leftPaddleY    (leftPaddleY),
        .rightPaddleY   (rightPaddleY),
        .startButton    (startButton),
        .isHittingLeft  (isHittingLeft),
        .isHittingRight (isHittingRight),
        .scoreLeft      (scoreLeft),
        .scoreRight     (scoreRight),
        .ballResetN     (ballResetN),
        .gameState      (gameState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        isBallMoving = 1'b1;
        tick();
        isBallMoving = 1'b0;
    endtask

    // Counts samples spent in POINT (bounded) and whether ballResetN stayed low.
    task automatic wait_point(output int n, output logic ok);
        n  = 0;
        ok = 1'b1;
        while (gameState == 2'd2 && n < 40) begin
            if (ballResetN !== 1'b0) ok = 1'b0;
            n++;
            tick();
        end
    endtask

    initial begin
        reset        = 1'b0;
        xPosition    = 6'd30;
        yPosition    = 5'd0;
        isBallMoving = 1'b0;
        leftPaddleY  = 5'd10;
        rightPaddleY = 5'd20;
        startButton  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", gameState, 0);
        check("rst_score_l", scoreLeft, 0);
        check("rst_score_r", scoreRight, 0);
        check("rst_ballresetn", ballResetN, 0);
        check("rst_hit_l", isHittingLeft, 0);
        check("rst_hit_r", isHittingRight, 0);

        // Release reset, start the game
        reset = 1'b1;
        tick();
        check("idle_hold", gameState, 0);
        startButton = 1'b1;
        tick();
        startButton = 1'b0;
        check("start_state", gameState, 1);
        check("start_ballresetn", ballResetN, 1);
        check("start_score_l", scoreLeft, 0);
        check("start_score_r", scoreRight, 0);

        // Left hit: y=12 within rows 10..13
        yPosition = 5'd12;
        xPosition = 6'd1;
        #1;
        check("hit_l_latency", isHittingLeft, 0);
        strobe();
        check("hit_l", isHittingLeft, 1);
        check("hit_l_score_r", scoreRight, 0);
        check("hit_l_state", gameState, 1);

        // Left miss: y=20 outside 10..13
        yPosition = 5'd20;
        strobe();
        xPosition = 6'd30;
        check("miss_l_score_r", scoreRight, 1);
        check("miss_l_state", gameState, 2);
        check("miss_l_hit_cleared", isHittingLeft, 0);
        wait_point(n_point, low_ok);
        check("point_len", n_point, 16);
        check("point_ballresetn_low", low_ok, 1);
        check("point_back_state", gameState, 1);
        check("point_back_ballresetn", ballResetN, 1);

        // Right paddle at the bottom edge: rows 30..31
        rightPaddleY = 5'd30;
        yPosition    = 5'd31;
        xPosition    = 6'd63;
        strobe();
        check("hit_r_bottom", isHittingRight, 1);
        check("hit_r_score_l", scoreLeft, 0);
        check("hit_r_state", gameState, 1);

        // Row 29 is only inside the span with the grace rows enabled
        yPosition = 5'd29;
        xPosition = 6'd40;
        tick();
`ifdef PONG_REFEREE_GRACE_EN
        check("grace_row29", isHittingRight, 1);
`else
        check("grace_row29", isHittingRight, 0);
`endif

        // Row 0 must not alias into the 30..33 span
        yPosition = 5'd0;
        xPosition = 6'd63;
        strobe();
        check("miss_r_nowrap_score_l", scoreLeft, 1);
        check("miss_r_nowrap_state", gameState, 2);
        wait_point(n_point, low_ok);
        check("point2_len", n_point, 16);

        // Eight more right misses reach WIN_SCORE
        for (int i = 0; i < 8; i++) begin
            strobe();
            if (i < 7) wait_point(n_point, low_ok);
        end
        check("win_score_l", scoreLeft, 9);
        check("win_state", gameState, 3);
        check("win_ballresetn", ballResetN, 0);

        // Strobes in OVER are ignored
        strobe();
        xPosition = 6'd1;
        yPosition = 5'd25;
        strobe();
        check("over_frozen_l", scoreLeft, 9);
        check("over_frozen_r", scoreRight, 1);
        check("over_state", gameState, 3);

        // Restart from OVER
        xPosition   = 6'd30;
        startButton = 1'b1;
        tick();
        startButton = 1'b0;
        check("restart_state", gameState, 1);
        check("restart_score_l", scoreLeft, 0);
        check("restart_score_r", scoreRight, 0);

        // Reset mid-POINT with the hold counter at 7
        xPosition = 6'd1;
        yPosition = 5'd20;
        strobe();
        xPosition = 6'd30;
        check("mid_point_entry", gameState, 2);
        check("mid_point_score_r", scoreRight, 1);
        for (int i = 0; i < 8; i++) tick();
        check("mid_point_still", gameState, 2);
        reset = 1'b0;
        #1;
        check("async_rst_state", gameState, 0);
        check("async_rst_score_l", scoreLeft, 0);
        check("async_rst_score_r", scoreRight, 0);
        check("async_rst_ballresetn", ballResetN, 0);
        check("async_rst_hit_l", isHittingLeft, 0);
        check("async_rst_hit_r", isHittingRight, 0);

        // Button held through reset must not start a game
        startButton = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("held_start_ignored", gameState, 0);
        startButton = 1'b0;
        tick();
        startButton = 1'b1;
        tick();
        startButton = 1'b0;
        check("fresh_edge_start", gameState, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
